// File: rtl/vga_board_adapter_pkg.sv
// Shared types and helpers for the board I/O adapter.
// Holds the 2x2 ordered-dither table and colour quantiser.
package board_io_pkg;

    localparam int QW = 16;

    localparam logic [1:0] BAYER2X2 [2][2] = '{
        '{2'd0, 2'd2},
        '{2'd3, 2'd1}
    };

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } vctl_t;

    // Round up by one step when the residual beats the threshold, never wrapping.
    function automatic logic [QW-1:0] quantise(
        input logic [QW-1:0] q,
        input logic [QW-1:0] qmax,
        input logic [1:0]    r,
        input logic [1:0]    t,
        input logic          en
    );
        if (en && (r > t) && (q != qmax))
            return q + 16'd1;
        return q;
    endfunction

    function automatic logic sync_active(
        input logic lvl,
        input logic act_low
    );
        return lvl ^ act_low;
    endfunction

endpackage

// File: rtl/vga_board_adapter_if.sv
// Video bundle between the game core and the board pins.
interface vga_board_adapter_if #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 4
);
    logic                HSYNC_IN;
    logic                VSYNC_IN;
    logic                DE_IN;
    logic [IN_BITS-1:0]  RED_IN;
    logic [IN_BITS-1:0]  GREEN_IN;
    logic [IN_BITS-1:0]  BLUE_IN;
    logic                VGA_HS;
    logic                VGA_VS;
    logic [OUT_BITS-1:0] VGA_R;
    logic [OUT_BITS-1:0] VGA_G;
    logic [OUT_BITS-1:0] VGA_B;

    modport master (
        output HSYNC_IN, VSYNC_IN, DE_IN,
        output RED_IN, GREEN_IN, BLUE_IN,
        input  VGA_HS, VGA_VS,
        input  VGA_R, VGA_G, VGA_B
    );

    modport slave (
        input  HSYNC_IN, VSYNC_IN, DE_IN,
        input  RED_IN, GREEN_IN, BLUE_IN,
        output VGA_HS, VGA_VS,
        output VGA_R, VGA_G, VGA_B
    );

endinterface

// File: rtl/vga_board_adapter_btn.sv
// One push-button channel: synchronise, polarity-fix, debounce,
// and strobe on an accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit BTN_ACTIVE_LOW  = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_btn,
    output logic o_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_btn;
    logic          r_press;
    logic [CW-1:0] r_cnt;
    logic          w_s;
    logic          w_acc;

    assign w_s   = r_sync2 ^ BTN_ACTIVE_LOW;
    assign w_acc = (w_s != r_btn) &&
                   (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

    // Synchronisers park at the released level so reset never looks like a press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= BTN_ACTIVE_LOW;
            r_sync2 <= BTN_ACTIVE_LOW;
            r_btn   <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_press <= w_acc & w_s;
            if (w_s == r_btn) begin
                r_cnt <= '0;
            end else if (w_acc) begin
                r_btn <= w_s;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_btn   = r_btn;
    assign o_press = r_press;

endmodule

// File: rtl/vga_board_adapter.sv
// Board adapter: debounced buttons plus a 2-stage VGA pipe
// reducing core colour to the DAC width with ordered dither.
module vga_board_adapter
    import board_io_pkg::*;
#(
    parameter int N_BTN           = 2,
    parameter bit BTN_ACTIVE_LOW  = 1,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int IN_BITS         = 8,
    parameter int OUT_BITS        = 4,
    parameter bit DITHER          = 1,
    parameter bit SYNC_ACTIVE_LOW = 1
) (
    input  logic             CLK_25MHZ,
    input  logic             RESET_N,
    input  logic [N_BTN-1:0] KEY_RAW,
    output logic [N_BTN-1:0] BTN,
    output logic [N_BTN-1:0] BTN_PRESS,
    vga_board_adapter_if.slave vid
);
    localparam int   RW      = IN_BITS - OUT_BITS;
    localparam logic S_IDLE  = SYNC_ACTIVE_LOW;

    vctl_t               r_s1_ctl;
    vctl_t               r_s2_ctl;
    logic [IN_BITS-1:0]  r_s1_col [3];
    logic [OUT_BITS-1:0] r_s2_col [3];
    logic [OUT_BITS-1:0] w_out    [3];
    logic                r_px;
    logic                r_py;
    logic                r_fr;
    logic [1:0]          w_t;
    logic                w_vs_edge;
    logic                w_de_fall;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
        ) u_db (
            .i_clk   (CLK_25MHZ),
            .i_rst_n (RESET_N),
            .i_raw   (KEY_RAW[i]),
            .o_btn   (BTN[i]),
            .o_press (BTN_PRESS[i])
        );
    end

    // Stage 2 holds the previous stage-1 controls, so edges come for free.
    assign w_vs_edge = sync_active(r_s1_ctl.vs, SYNC_ACTIVE_LOW) &&
                       !sync_active(r_s2_ctl.vs, SYNC_ACTIVE_LOW);
    assign w_de_fall = r_s2_ctl.de && !r_s1_ctl.de;
    assign w_t       = BAYER2X2[r_py][r_px ^ r_fr];

    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        logic [1:0] w_r;
        if (RW >= 2) begin : g_r2
            assign w_r = r_s1_col[ch][RW-1 -: 2];
        end else if (RW == 1) begin : g_r1
            assign w_r = {r_s1_col[ch][0], 1'b0};
        end else begin : g_r0
            assign w_r = 2'b00;
        end
        if (RW > 2) begin : g_lsb
            logic w_unused_lsb;
            assign w_unused_lsb = ^r_s1_col[ch][RW-3:0];
        end
        assign w_out[ch] = OUT_BITS'(quantise(
            QW'(r_s1_col[ch][IN_BITS-1 -: OUT_BITS]),
            QW'({OUT_BITS{1'b1}}),
            w_r, w_t, DITHER));
    end

    always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            r_s1_ctl <= '{hs: S_IDLE, vs: S_IDLE, de: 1'b0};
            r_s2_ctl <= '{hs: S_IDLE, vs: S_IDLE, de: 1'b0};
            for (int i = 0; i < 3; i++) begin
                r_s1_col[i] <= '0;
                r_s2_col[i] <= '0;
            end
        end else begin
            r_s1_ctl <= '{hs: vid.HSYNC_IN,
                          vs: vid.VSYNC_IN,
                          de: vid.DE_IN};
            r_s1_col[0] <= vid.RED_IN;
            r_s1_col[1] <= vid.GREEN_IN;
            r_s1_col[2] <= vid.BLUE_IN;
            r_s2_ctl <= r_s1_ctl;
            for (int i = 0; i < 3; i++)
                r_s2_col[i] <= r_s1_ctl.de ? w_out[i] : '0;
        end
    end

    always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            r_px <= 1'b0;
            r_py <= 1'b0;
            r_fr <= 1'b0;
        end else begin
            r_px <= r_s1_ctl.de ? ~r_px : 1'b0;
            if (w_vs_edge) begin
                r_py <= 1'b0;
                r_fr <= ~r_fr;
            end else if (w_de_fall) begin
                r_py <= ~r_py;
            end
        end
    end

    assign vid.VGA_HS = r_s2_ctl.hs;
    assign vid.VGA_VS = r_s2_ctl.vs;
    assign vid.VGA_R  = r_s2_col[0];
    assign vid.VGA_G  = r_s2_col[1];
    assign vid.VGA_B  = r_s2_col[2];

endmodule

// File: tb/tb_vga_board_adapter.sv
// Bench for vga_board_adapter: directed button sequences and
// randomised video frames scored against a pixel-level model.
module tb_vga_board_adapter;
    localparam int DEB = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] key;
    logic [1:0] btn, press, btn_t, press_t;

    always #20 clk = ~clk;

    vga_board_adapter_if #(.IN_BITS(8), .OUT_BITS(4)) vd ();
    vga_board_adapter_if #(.IN_BITS(8), .OUT_BITS(4)) vt ();

    vga_board_adapter #(
        .N_BTN(2), .BTN_ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DEB),
        .IN_BITS(8), .OUT_BITS(4), .DITHER(1), .SYNC_ACTIVE_LOW(1)
    ) u_dut (
        .CLK_25MHZ(clk), .RESET_N(rst_n), .KEY_RAW(key),
        .BTN(btn), .BTN_PRESS(press), .vid(vd)
    );

    vga_board_adapter #(
        .N_BTN(2), .BTN_ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DEB),
        .IN_BITS(8), .OUT_BITS(4), .DITHER(0), .SYNC_ACTIVE_LOW(1)
    ) u_trunc (
        .CLK_25MHZ(clk), .RESET_N(rst_n), .KEY_RAW(key),
        .BTN(btn_t), .BTN_PRESS(press_t), .vid(vt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic [11:0] cd;
        logic [11:0] ct;
    } exp_t;

    exp_t sbq[$];
    int   mx, my, mf;
    bit   pde, pact;
    int   bay [2][2] = '{'{0, 2}, '{3, 1}};

    // Pixel value from the dither rule stated in pixel/line/frame terms.
    function automatic logic [3:0] ref_px(input logic [7:0] c, input bit dith,
                                          input int x, input int y, input int f);
        int q, r, t;
        q = c / 16;
        r = (c % 16) / 4;
        t = bay[y % 2][(x % 2) ^ (f % 2)];
        if (dith && r > t && q < 15) q++;
        return q[3:0];
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; mf = 0; pde = 0; pact = 0;
        sbq.delete();
    endtask

    task automatic drive(input bit hs, input bit vs, input bit de,
                         input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b);
        vd.HSYNC_IN = hs; vd.VSYNC_IN = vs; vd.DE_IN = de;
        vd.RED_IN = r; vd.GREEN_IN = g; vd.BLUE_IN = b;
        vt.HSYNC_IN = hs; vt.VSYNC_IN = vs; vt.DE_IN = de;
        vt.RED_IN = r; vt.GREEN_IN = g; vt.BLUE_IN = b;
    endtask

    task automatic step(input bit hs, input bit vs, input bit de,
                        input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b);
        exp_t e;
        bit   act;
        drive(hs, vs, de, r, g, b);
        e.hs = hs;
        e.vs = vs;
        e.cd = de ? {ref_px(r, 1, mx, my, mf), ref_px(g, 1, mx, my, mf),
                     ref_px(b, 1, mx, my, mf)} : 12'h000;
        e.ct = de ? {ref_px(r, 0, mx, my, mf), ref_px(g, 0, mx, my, mf),
                     ref_px(b, 0, mx, my, mf)} : 12'h000;
        sbq.push_back(e);
        act = !vs;
        if (act && !pact) begin
            mf++;
            my = 0;
        end else if (pde && !de) begin
            my++;
        end
        mx = de ? mx + 1 : 0;
        pde = de;
        pact = act;
        @(posedge clk);
        #1;
        if (sbq.size() == 2) begin
            e = sbq.pop_front();
            chk("sync_dith", 32'({vd.VGA_HS, vd.VGA_VS}), 32'({e.hs, e.vs}));
            chk("rgb_dith", 32'({vd.VGA_R, vd.VGA_G, vd.VGA_B}), 32'(e.cd));
            chk("sync_trunc", 32'({vt.VGA_HS, vt.VGA_VS}), 32'({e.hs, e.vs}));
            chk("rgb_trunc", 32'({vt.VGA_R, vt.VGA_G, vt.VGA_B}), 32'(e.ct));
        end
    endtask

    task automatic frame(input int lines, input int w,
                         input logic [7:0] c, input bit rnd);
        logic [7:0] r, g, b;
        repeat (2) step(1, 0, 0, 8'hFF, 8'hFF, 8'hFF);
        step(1, 1, 0, 8'hFF, 8'hFF, 8'hFF);
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < w; p++) begin
                r = rnd ? 8'($urandom) : c;
                g = rnd ? 8'($urandom) : c;
                b = rnd ? 8'($urandom) : c;
                step(1, 1, 1, r, g, b);
            end
            repeat (2) step(0, 1, 0, 8'hFF, 8'hFF, 8'hFF);
            step(1, 1, 0, 8'hFF, 8'hFF, 8'hFF);
        end
    endtask

    initial begin
        int n, pc;
        bit hit, seen;
        key = 2'b00;
        drive(1, 1, 0, 8'hFF, 8'hFF, 8'hFF);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_btn", 32'(btn), 32'd0);
        chk("rst_press", 32'(press), 32'd0);
        chk("rst_sync", 32'({vd.VGA_HS, vd.VGA_VS}), 32'h3);
        chk("rst_rgb", 32'({vd.VGA_R, vd.VGA_G, vd.VGA_B}), 32'd0);
        chk("rst_rgb_t", 32'({vt.VGA_R, vt.VGA_G, vt.VGA_B}), 32'd0);

        @(negedge clk);
        key = 2'b11;
        rst_n = 1'b1;
        model_reset();
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (press != 2'b00 || btn != 2'b00) seen = 1;
        end
        chk("no_press_after_rst", 32'(seen), 32'd0);

        // Bouncy press on key 0.
        @(negedge clk) key[0] = 1'b0;
        repeat (5) @(negedge clk);
        key[0] = 1'b1;
        repeat (2) @(negedge clk);
        key[0] = 1'b0;
        n = 0; pc = 0; hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(posedge clk);
            #1;
            n++;
            pc += int'(press[0]);
            if (btn[0]) begin
                hit = 1;
                chk("press_at_rise", 32'(press[0]), 32'd1);
            end
        end
        chk("btn_rise_latency", 32'(n), 32'(DEB + 2));
        repeat (30) begin
            @(posedge clk);
            #1;
            pc += int'(press[0]);
        end
        chk("press_count", 32'(pc), 32'd1);
        chk("btn_held", 32'(btn), 32'b01);
        chk("press1_idle", 32'(press[1]), 32'd0);

        @(negedge clk) key[0] = 1'b1;
        n = 0; pc = 0; hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(posedge clk);
            #1;
            n++;
            pc += int'(press[0]);
            if (!btn[0]) hit = 1;
        end
        chk("btn_fall_latency", 32'(n), 32'(DEB + 2));
        chk("no_release_press", 32'(pc), 32'd0);

        // Video: truncation, dither pattern over frames, random, saturation.
        @(negedge clk);
        frame(2, 4, 8'hA7, 0);
        frame(2, 4, 8'h48, 0);
        frame(2, 4, 8'h48, 0);
        frame(3, 6, 8'h00, 1);
        frame(3, 6, 8'h00, 1);
        frame(2, 4, 8'hFF, 0);

        // Reset in the middle of a visible line.
        repeat (2) step(1, 0, 0, 8'hFF, 8'hFF, 8'hFF);
        step(1, 1, 0, 8'hFF, 8'hFF, 8'hFF);
        repeat (3) step(1, 1, 1, 8'hFF, 8'h48, 8'hA7);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_rgb", 32'({vd.VGA_R, vd.VGA_G, vd.VGA_B}), 32'd0);
        chk("midrst_sync", 32'({vd.VGA_HS, vd.VGA_VS}), 32'h3);
        @(posedge clk);
        #1;
        chk("midrst_rgb_edge", 32'({vd.VGA_R, vd.VGA_G, vd.VGA_B}), 32'd0);
        chk("midrst_btn", 32'(btn), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        frame(2, 4, 8'h48, 0);
        frame(3, 5, 8'h00, 1);
        step(1, 1, 0, 8'hFF, 8'hFF, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
